// File: rtl/ate_pkg.sv
// Shared geometry for the raster-to-block feeder and the adaptive-threshold engine.
// Address and counter widths are all derived from the image and block sizes here.
package ate_pkg;

   function automatic int unsigned clog2(input int unsigned value);
      int unsigned w;
      w = 0;
      while ((32'd1 << w) < value) w++;
      return (w == 0) ? 1 : w;
   endfunction

   localparam int unsigned IMG_W        = 48;
   localparam int unsigned IMG_H        = 32;
   localparam int unsigned BLK          = 8;
   localparam int unsigned PIX_W        = 8;
   localparam int unsigned BLKS_PER_ROW = IMG_W / BLK;
   localparam int unsigned BANDS        = IMG_H / BLK;
   localparam int unsigned BAND_PIX     = IMG_W * BLK;

   localparam int unsigned AW     = clog2(2 * BAND_PIX);
   localparam int unsigned OFFS_W = AW - 1;
   localparam int unsigned COL_W  = clog2(IMG_W);
   localparam int unsigned ROW_W  = clog2(BLK);
   localparam int unsigned BB_W   = clog2(BLKS_PER_ROW);
   localparam int unsigned BAND_W = clog2(BANDS);

   localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(IMG_W - 1);
   localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(BLK - 1);
   localparam logic [BB_W-1:0]   BB_LAST   = BB_W'(BLKS_PER_ROW - 1);
   localparam logic [BAND_W-1:0] BAND_LAST = BAND_W'(BANDS - 1);

endpackage

// File: rtl/raster_to_block_if.sv
// Pixel stream bundle: raster input with valid/ready handshake and the
// block-ordered output stream with its block/frame sideband flags.
interface raster_to_block_if;
   import ate_pkg::*;

   logic [PIX_W-1:0] pix_in;
   logic             pix_in_valid;
   logic             pix_in_ready;
   logic [PIX_W-1:0] pix_out;
   logic             pix_out_valid;
   logic             block_first;
   logic             block_last;
   logic             frame_last;

   modport master (
      output pix_in, pix_in_valid,
      input  pix_in_ready, pix_out, pix_out_valid, block_first, block_last, frame_last
   );

   modport slave (
      input  pix_in, pix_in_valid,
      output pix_in_ready, pix_out, pix_out_valid, block_first, block_last, frame_last
   );
endinterface

// File: rtl/raster_to_block_band_ram.sv
// Simple dual-port band buffer: one write port, one synchronous read port.
// The bank bit is the address MSB, so the array spans a power-of-two depth.
module band_ram
   import ate_pkg::*;
(
   input  logic             i_clk,
   input  logic             i_we,
   input  logic [AW-1:0]    i_waddr,
   input  logic [PIX_W-1:0] i_wdata,
   input  logic             i_re,
   input  logic [AW-1:0]    i_raddr,
   output logic [PIX_W-1:0] o_rdata
);
   localparam int unsigned DEPTH = 1 << AW;

   logic [PIX_W-1:0] r_mem [DEPTH];
   logic [PIX_W-1:0] r_rdata;

   always_ff @(posedge i_clk) begin
      if (i_we) r_mem[i_waddr] <= i_wdata;
      if (i_re) r_rdata <= r_mem[i_raddr];
   end

   assign o_rdata = r_rdata;
endmodule

// File: rtl/raster_to_block.sv
// Reorders a raster pixel stream into 8x8 block order through a ping-pong
// 8-row band buffer; a full band is read out with no gaps.
module raster_to_block
   import ate_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   raster_to_block_if.slave  bus
);
   logic [COL_W-1:0]  r_wr_col;
   logic [ROW_W-1:0]  r_wr_row;
   logic              r_wr_bank;
   logic [1:0]        r_full;
   logic [ROW_W-1:0]  r_rd_c;
   logic [ROW_W-1:0]  r_rd_r;
   logic [BB_W-1:0]   r_rd_b;
   logic [BAND_W-1:0] r_rd_band;
   logic              r_rd_bank;
   logic              r_s1_valid, r_s1_first, r_s1_last, r_s1_frame;

   logic              w_wr_en, w_wr_done, w_rd_en, w_rd_done, w_rd_first, w_rd_last;
   logic [OFFS_W-1:0] w_wr_offs, w_rd_offs;
   logic [PIX_W-1:0]  w_ram_q;

   assign bus.pix_in_ready = !r_full[r_wr_bank];
   assign w_wr_en   = bus.pix_in_valid && !r_full[r_wr_bank];
   assign w_wr_done = w_wr_en && (r_wr_col == COL_LAST) && (r_wr_row == ROW_LAST);
   assign w_wr_offs = OFFS_W'(r_wr_row) * OFFS_W'(IMG_W) + OFFS_W'(r_wr_col);

   assign w_rd_en    = r_full[r_rd_bank];
   assign w_rd_first = (r_rd_r == '0) && (r_rd_c == '0);
   assign w_rd_last  = (r_rd_r == ROW_LAST) && (r_rd_c == ROW_LAST);
   assign w_rd_done  = w_rd_en && w_rd_last && (r_rd_b == BB_LAST);
   assign w_rd_offs  = OFFS_W'(r_rd_r) * OFFS_W'(IMG_W) + OFFS_W'(r_rd_b) * OFFS_W'(BLK)
                     + OFFS_W'(r_rd_c);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_wr_col  <= '0;
         r_wr_row  <= '0;
         r_wr_bank <= 1'b0;
      end else if (w_wr_en) begin
         if (r_wr_col == COL_LAST) begin
            r_wr_col <= '0;
            if (r_wr_row == ROW_LAST) begin
               r_wr_row  <= '0;
               r_wr_bank <= ~r_wr_bank;
            end else begin
               r_wr_row <= r_wr_row + ROW_W'(1);
            end
         end else begin
            r_wr_col <= r_wr_col + COL_W'(1);
         end
      end
   end

   // Set and clear always target different banks, so both may land in one cycle.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_full <= '0;
      end else begin
         if (w_wr_done) r_full[r_wr_bank] <= 1'b1;
         if (w_rd_done) r_full[r_rd_bank] <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_rd_c    <= '0;
         r_rd_r    <= '0;
         r_rd_b    <= '0;
         r_rd_band <= '0;
         r_rd_bank <= 1'b0;
      end else if (w_rd_en) begin
         if (r_rd_c == ROW_LAST) begin
            r_rd_c <= '0;
            if (r_rd_r == ROW_LAST) begin
               r_rd_r <= '0;
               if (r_rd_b == BB_LAST) begin
                  r_rd_b    <= '0;
                  r_rd_bank <= ~r_rd_bank;
                  r_rd_band <= (r_rd_band == BAND_LAST) ? '0 : r_rd_band + BAND_W'(1);
               end else begin
                  r_rd_b <= r_rd_b + BB_W'(1);
               end
            end else begin
               r_rd_r <= r_rd_r + ROW_W'(1);
            end
         end else begin
            r_rd_c <= r_rd_c + ROW_W'(1);
         end
      end
   end

   band_ram u_band_ram (
      .i_clk   (clk),
      .i_we    (w_wr_en),
      .i_waddr ({r_wr_bank, w_wr_offs}),
      .i_wdata (bus.pix_in),
      .i_re    (w_rd_en),
      .i_raddr ({r_rd_bank, w_rd_offs}),
      .o_rdata (w_ram_q)
   );

   // Flags ride alongside the RAM read stage so they stay aligned with pix_out.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_s1_valid <= 1'b0;
         r_s1_first <= 1'b0;
         r_s1_last  <= 1'b0;
         r_s1_frame <= 1'b0;
      end else begin
         r_s1_valid <= w_rd_en;
         r_s1_first <= w_rd_en && w_rd_first;
         r_s1_last  <= w_rd_en && w_rd_last;
         r_s1_frame <= w_rd_done && (r_rd_band == BAND_LAST);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         bus.pix_out       <= '0;
         bus.pix_out_valid <= 1'b0;
         bus.block_first   <= 1'b0;
         bus.block_last    <= 1'b0;
         bus.frame_last    <= 1'b0;
      end else begin
         bus.pix_out_valid <= r_s1_valid;
         bus.block_first   <= r_s1_first;
         bus.block_last    <= r_s1_last;
         bus.frame_last    <= r_s1_frame;
         if (r_s1_valid) bus.pix_out <= w_ram_q;
      end
   end
endmodule
